ammod_ramp: RTL

Parametrised successor modulator for the DAC-side signal chain. Per clock it multiplies NSLICE complex carrier phasors by NSLICE complex envelope samples and by a scalar amplitude. The amplitude is produced by an on-chip linear ramp state machine keyed by gatein, so pulse edges rise and fall without spectral splatter. It adds:

- width and slice-count parameters,
- a per-sample mode select,
- saturating arithmetic in place of wrap-around.

---
 rtl/ammod_ramp.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ammod_ramp.sv
// ammod_ramp -- amplitude-ramped complex modulator for the DAC-side chain.
//
// Per clock, NSLICE complex carrier phasors are multiplied by NSLICE complex
// envelope samples and then by a scalar amplitude. The amplitude comes from
// a linear ramp FSM keyed by gatein, so pulse edges rise and fall smoothly.
// All arithmetic saturates instead of wrapping.
//
// Ports:
//   clk         sole clock
//   reset       asynchronous, active-high reset
//   gatein      pulse gate: rising edge ramps up, falling edge ramps down
//   mode        0 carrier*env*amp, 1 env*amp, 2 carrier*amp, 3 zero
//   amp_target  unsigned hold amplitude, clamped to 2^(DW-1)-1
//   ramp_step   unsigned amplitude step per clock (0 = jump directly)
//   carrier     NSLICE x {cos,sin}, slice i at [2DW*i +: 2DW], cos in upper half
//   env         NSLICE x {x,y},     slice i at [2DW*i +: 2DW], x in upper half
//   multix      NSLICE real outputs, slice i at [DW*i +: DW]
//   multiy      NSLICE imaginary outputs, same packing
//   gateout     high when the aligned output sample came from a non-IDLE state
//   ramp_state  live FSM state: 0 IDLE, 1 RAMPUP, 2 HOLD, 3 RAMPDN
//
// Pipeline: stage 1 registers inputs with the current amplitude and gate,
// stage 2 forms the carrier*env product, stage 3 applies the amplitude,
// stage 4 is the output register. Latency is 4 clock edges.

module ammod_ramp #(
  parameter int unsigned NSLICE = 16,
  parameter int unsigned DW     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     gatein,
  input  logic [1:0]               mode,
  input  logic [DW-1:0]            amp_target,
  input  logic [DW-1:0]            ramp_step,
  input  logic [NSLICE*2*DW-1:0]   carrier,
  input  logic [NSLICE*2*DW-1:0]   env,
  output logic [NSLICE*DW-1:0]     multix,
  output logic [NSLICE*DW-1:0]     multiy,
  output logic                     gateout,
  output logic [1:0]               ramp_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMPUP = 2'd1,
    HOLD   = 2'd2,
    RAMPDN = 2'd3
  } state_e;

  localparam logic [DW-1:0] AMP_MAX = {1'b0, {(DW-1){1'b1}}};

  // Arithmetic shift right by DW-1 (floor), then clamp to the signed DW range.
  function automatic logic [DW-1:0] sat_shift(input logic signed [2*DW:0] v);
    logic signed [2*DW:0] sh;
    sh = v >>> (DW-1);
    if ((&sh[2*DW:DW-1]) || !(|sh[2*DW:DW-1]))
      return sh[DW-1:0];
    else if (sh[2*DW])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // ---------------------------------------------------------------------------
  // Ramp FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [DW-1:0] amp_q, amp_d;
  logic [DW-1:0] tgt, up_val, dn_val;
  logic [DW:0]   up_sum;

  // up_val/dn_val are the amplitude after one step up/down; the extra sum bit
  // keeps amp+step from wrapping. A zero step jumps straight to T or 0.
  always_comb begin
    tgt    = (amp_target > AMP_MAX) ? AMP_MAX : amp_target;
    up_sum = {1'b0, amp_q} + {1'b0, ramp_step};
    if (ramp_step == '0 || up_sum > {1'b0, tgt})
      up_val = tgt;
    else
      up_val = up_sum[DW-1:0];
    if (ramp_step == '0 || amp_q <= ramp_step)
      dn_val = '0;
    else
      dn_val = amp_q - ramp_step;
  end

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    unique case (state_q)
      IDLE: begin
        amp_d = '0;
        if (gatein) begin
          state_d = RAMPUP;
          amp_d   = up_val;
        end
      end
      RAMPUP: begin
        if (!gatein) begin
          state_d = RAMPDN;
          amp_d   = dn_val;
        end else begin
          amp_d = up_val;
          if (up_val == tgt) state_d = HOLD;
        end
      end
      HOLD: begin
        if (!gatein) begin
          state_d = RAMPDN;
          amp_d   = dn_val;
        end else begin
          amp_d = tgt;
        end
      end
      RAMPDN: begin
        if (gatein) begin
          state_d = RAMPUP;
          amp_d   = up_val;
        end else begin
          amp_d = dn_val;
          if (dn_val == '0) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        amp_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      amp_q   <= '0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [NSLICE*2*DW-1:0] c1_q, e1_q;
  logic [1:0]             mode1_q;
  logic [DW-1:0]          amp1_q, amp2_q;
  logic                   gate1_q, gate2_q, gate3_q, gate4_q;
  logic [NSLICE*DW-1:0]   zx_d, zy_d, zx2_q, zy2_q;
  logic [NSLICE*DW-1:0]   ox_d, oy_d, ox3_q, oy3_q, ox4_q, oy4_q;

  // Stage 2: complex product carrier*env (or a bypass selected by mode).
  // Mode 3 is zeroed here so later stages need not carry mode.
  always_comb begin
    zx_d = '0;
    zy_d = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin : g_cmul
      logic signed [DW-1:0]   c, s, x, y;
      logic signed [2*DW-1:0] pcx, psy, pcy, psx;
      logic signed [2*DW:0]   zr, zi;
      c   = c1_q[2*DW*i+DW +: DW];
      s   = c1_q[2*DW*i    +: DW];
      x   = e1_q[2*DW*i+DW +: DW];
      y   = e1_q[2*DW*i    +: DW];
      pcx = (2*DW)'(c) * (2*DW)'(x);
      psy = (2*DW)'(s) * (2*DW)'(y);
      pcy = (2*DW)'(c) * (2*DW)'(y);
      psx = (2*DW)'(s) * (2*DW)'(x);
      zr  = (2*DW+1)'(pcx) - (2*DW+1)'(psy);
      zi  = (2*DW+1)'(pcy) + (2*DW+1)'(psx);
      unique case (mode1_q)
        2'd0: begin
          zx_d[DW*i +: DW] = sat_shift(zr);
          zy_d[DW*i +: DW] = sat_shift(zi);
        end
        2'd1: begin
          zx_d[DW*i +: DW] = x;
          zy_d[DW*i +: DW] = y;
        end
        2'd2: begin
          zx_d[DW*i +: DW] = c;
          zy_d[DW*i +: DW] = s;
        end
        default: begin
          zx_d[DW*i +: DW] = '0;
          zy_d[DW*i +: DW] = '0;
        end
      endcase
    end
  end

  // Stage 3: scale by the (non-negative) amplitude that travelled with the data.
  always_comb begin
    ox_d = '0;
    oy_d = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin : g_amul
      logic signed [DW:0]   a;
      logic signed [2*DW:0] px, py;
      a  = $signed({1'b0, amp2_q});
      px = (2*DW+1)'($signed(zx2_q[DW*i +: DW])) * (2*DW+1)'(a);
      py = (2*DW+1)'($signed(zy2_q[DW*i +: DW])) * (2*DW+1)'(a);
      ox_d[DW*i +: DW] = sat_shift(px);
      oy_d[DW*i +: DW] = sat_shift(py);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c1_q    <= '0;
      e1_q    <= '0;
      mode1_q <= '0;
      amp1_q  <= '0;
      gate1_q <= 1'b0;
      zx2_q   <= '0;
      zy2_q   <= '0;
      amp2_q  <= '0;
      gate2_q <= 1'b0;
      ox3_q   <= '0;
      oy3_q   <= '0;
      gate3_q <= 1'b0;
      ox4_q   <= '0;
      oy4_q   <= '0;
      gate4_q <= 1'b0;
    end else begin
      c1_q    <= carrier;
      e1_q    <= env;
      mode1_q <= mode;
      amp1_q  <= amp_q;
      gate1_q <= (state_q != IDLE);
      zx2_q   <= zx_d;
      zy2_q   <= zy_d;
      amp2_q  <= amp1_q;
      gate2_q <= gate1_q;
      ox3_q   <= ox_d;
      oy3_q   <= oy_d;
      gate3_q <= gate2_q;
      ox4_q   <= ox3_q;
      oy4_q   <= oy3_q;
      gate4_q <= gate3_q;
    end
  end

  assign multix     = ox4_q;
  assign multiy     = oy4_q;
  assign gateout    = gate4_q;
  assign ramp_state = state_q;

endmodule
